// File: rtl/hp_wind_ctrl_pkg.sv
// Shared constants, state/winner encodings and small helpers for the HP/wind game-state block.
package hp_wind_ctrl_pkg;

    localparam logic [6:0]  HP_MAX    = 7'd100;
    localparam logic [1:0]  WIND_MAX  = 2'd3;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {IDLE, PLAY, OVER} game_state_t;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

    // Subtract damage from HP, clamping at zero instead of wrapping.
    function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [6:0] dmg);
        logic [7:0] diff;
        diff = {1'b0, hp} - {1'b0, dmg};
        return (hp > dmg) ? diff[6:0] : 7'd0;
    endfunction

    // A zero magnitude always maps to 3'b000 so "left, no wind" never appears.
    function automatic logic [2:0] draw_wind(input logic [15:0] r);
        logic [1:0] mag;
        mag = r[1:0];
        if (mag > WIND_MAX)
            mag = WIND_MAX;
        return (mag == 2'd0) ? 3'b000 : {r[2], mag};
    endfunction

endpackage

// File: rtl/hp_wind_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running, reloaded with SEED on reset.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk60MHz,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        fb;

    always_comb begin
        fb  = q_q[0] ^ q_q[2] ^ q_q[3] ^ q_q[5];
        q_d = {fb, q_q[15:1]};
    end

    always_ff @(posedge clk60MHz) begin
        if (!rst_n)
            q_q <= SEED;
        else
            q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/hp_wind_ctrl.sv
// Game-state source for the HP/wind overlay: HP with saturating damage, per-turn wind, game-over detection.
module hp_wind_ctrl
    import hp_wind_ctrl_pkg::*;
(
    input  logic       clk60MHz,
    input  logic       rst_n,
    input  logic       new_game,
    input  logic       turn_end,
    input  logic       hit_p1,
    input  logic       hit_p2,
    input  logic [6:0] damage,
    output logic [6:0] hp_player1,
    output logic [6:0] hp_player2,
    output logic [2:0] wind,
    output logic       game_over,
    output logic [1:0] winner
);

    logic [15:0] lfsr_val;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk60MHz (clk60MHz),
        .rst_n    (rst_n),
        .q        (lfsr_val)
    );

    game_state_t state_q, state_d;
    logic [6:0]  hp1_q, hp1_d, hp2_q, hp2_d;
    logic [2:0]  wind_q, wind_d;
    logic        game_over_q, game_over_d;
    logic [1:0]  winner_q, winner_d;
    logic [6:0]  hp1_hit, hp2_hit;

    always_comb begin
        state_d     = state_q;
        hp1_d       = hp1_q;
        hp2_d       = hp2_q;
        wind_d      = wind_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        hp1_hit     = hit_p1 ? sat_sub(hp1_q, damage) : hp1_q;
        hp2_hit     = hit_p2 ? sat_sub(hp2_q, damage) : hp2_q;

        // new_game restarts from any state and takes priority over hits and turn_end.
        if (new_game) begin
            state_d     = PLAY;
            hp1_d       = HP_MAX;
            hp2_d       = HP_MAX;
            wind_d      = draw_wind(lfsr_val);
            game_over_d = 1'b0;
            winner_d    = W_NONE;
        end else if (state_q == PLAY) begin
            hp1_d = hp1_hit;
            hp2_d = hp2_hit;
            if (hp1_hit == 7'd0 || hp2_hit == 7'd0) begin
                // A fatal hit suppresses any wind draw in the same cycle.
                state_d     = OVER;
                game_over_d = 1'b1;
                winner_d    = {hp1_hit == 7'd0, hp2_hit == 7'd0};
            end else if (turn_end) begin
                wind_d = draw_wind(lfsr_val);
            end
        end
    end

    always_ff @(posedge clk60MHz) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hp1_q       <= HP_MAX;
            hp2_q       <= HP_MAX;
            wind_q      <= 3'b000;
            game_over_q <= 1'b0;
            winner_q    <= W_NONE;
        end else begin
            state_q     <= state_d;
            hp1_q       <= hp1_d;
            hp2_q       <= hp2_d;
            wind_q      <= wind_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign hp_player1 = hp1_q;
    assign hp_player2 = hp2_q;
    assign wind       = wind_q;
    assign game_over  = game_over_q;
    assign winner     = winner_q;

endmodule
